// File: rtl/vga_timing_monitor.sv
// ============================================================================
// Module  : vga_timing_monitor
// Brief   : Rebuilds VGA pixel coordinates from hs/vs/blank, declares lock
//           on stable geometry and flags line/frame/blanking errors.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_monitor #(
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pixel_clk,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        pix_valid,
    output logic        locked,
    output logic [15:0] frame_count,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic        err_blank
);

    localparam logic [9:0]  c_H_ACTIVE     = 10'(H_ACTIVE);
    localparam logic [9:0]  c_H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]  c_H_SYNC_START = 10'(H_SYNC_START);
    localparam logic [9:0]  c_V_ACTIVE     = 10'(V_ACTIVE);
    localparam logic [9:0]  c_V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  c_V_SYNC_START = 10'(V_SYNC_START);
    localparam logic [10:0] c_H_TOTAL_M    = 11'(H_TOTAL);
    localparam logic [10:0] c_V_TOTAL_M    = 11'(V_TOTAL);
    localparam logic [7:0]  c_LOCK_FRAMES  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Input stage: pixel strobe and the sync/blank samples it qualifies.
    logic        r_pclk_q;
    logic        r_pstb;
    logic        r_hs_d;
    logic        r_vs_d;
    logic        r_blank_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pclk_q  <= 1'b0;
            r_pstb    <= 1'b0;
            r_hs_d    <= 1'b1;
            r_vs_d    <= 1'b1;
            r_blank_d <= 1'b0;
        end else begin
            r_pclk_q  <= pixel_clk;
            r_pstb    <= pixel_clk & ~r_pclk_q;
            r_hs_d    <= hs;
            r_vs_d    <= vs;
            r_blank_d <= blank;
        end
    end

    state_t      r_state;
    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [9:0]  r_hx;
    logic [9:0]  r_vy;
    logic [10:0] r_llen;
    logic        r_llen_valid;
    logic [10:0] r_lcnt;
    logic        r_hbad;
    logic [7:0]  r_good;
    logic        r_pix_valid;
    logic [15:0] r_frame_count;
    logic        r_err_hlen;
    logic        r_err_vlen;
    logic        r_err_blank;

    logic        w_hs_fall;
    logic        w_vs_fall;
    logic        w_hx_wrap;
    logic [9:0]  w_hx_nxt;
    logic [9:0]  w_vy_nxt;
    logic        w_vis;
    logic        w_hlen_bad;
    logic        w_vlen_bad;
    logic        w_frame_ok;

    always_comb begin
        w_hs_fall = r_pstb & r_hs_prev & ~r_hs_d;
        w_vs_fall = r_pstb & r_vs_prev & ~r_vs_d;
        w_hx_wrap = (r_hx == c_H_LAST);

        if (w_hs_fall)
            w_hx_nxt = c_H_SYNC_START;
        else if (w_hx_wrap)
            w_hx_nxt = 10'd0;
        else
            w_hx_nxt = r_hx + 10'd1;

        if (w_vs_fall)
            w_vy_nxt = c_V_SYNC_START;
        else if (!w_hs_fall && w_hx_wrap)
            w_vy_nxt = (r_vy == c_V_LAST) ? 10'd0 : r_vy + 10'd1;
        else
            w_vy_nxt = r_vy;

        w_vis      = (w_hx_nxt < c_H_ACTIVE) && (w_vy_nxt < c_V_ACTIVE);
        // The first hs fall after a search only opens the measurement window.
        w_hlen_bad = w_hs_fall & r_llen_valid & (r_llen != c_H_TOTAL_M);
        w_vlen_bad = w_vs_fall & (r_lcnt != c_V_TOTAL_M);
        w_frame_ok = w_vs_fall & ~w_vlen_bad & ~w_hlen_bad & ~r_hbad;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_SEARCH;
            r_hs_prev     <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_hx          <= 10'd0;
            r_vy          <= 10'd0;
            r_llen        <= 11'd0;
            r_llen_valid  <= 1'b0;
            r_lcnt        <= 11'd0;
            r_hbad        <= 1'b0;
            r_good        <= 8'd0;
            r_pix_valid   <= 1'b0;
            r_frame_count <= 16'd0;
            r_err_hlen    <= 1'b0;
            r_err_vlen    <= 1'b0;
            r_err_blank   <= 1'b0;
        end else begin
            r_pix_valid <= 1'b0;
            if (r_pstb) begin
                r_hs_prev <= r_hs_d;
                r_vs_prev <= r_vs_d;
                r_hx      <= w_hx_nxt;
                r_vy      <= w_vy_nxt;

                if (r_state == ST_SEARCH) begin
                    r_llen       <= 11'd0;
                    r_llen_valid <= 1'b0;
                    r_lcnt       <= 11'd0;
                    r_hbad       <= 1'b0;
                    r_good       <= 8'd0;
                end else begin
                    if (w_hs_fall) begin
                        r_llen       <= 11'd1;
                        r_llen_valid <= 1'b1;
                    end else if (r_llen != 11'h7FF) begin
                        r_llen <= r_llen + 11'd1;
                    end

                    if (w_vs_fall)
                        r_lcnt <= w_hs_fall ? 11'd1 : 11'd0;
                    else if (w_hs_fall && r_lcnt != 11'h7FF)
                        r_lcnt <= r_lcnt + 11'd1;

                    if (w_vs_fall)
                        r_hbad <= 1'b0;
                    else if (w_hlen_bad)
                        r_hbad <= 1'b1;
                end

                case (r_state)
                    ST_SEARCH: begin
                        if (w_vs_fall)
                            r_state <= ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (w_hlen_bad || w_vlen_bad) begin
                            r_good <= 8'd0;
                        end else if (w_frame_ok) begin
                            if ((r_good + 8'd1) >= c_LOCK_FRAMES) begin
                                r_good  <= 8'd0;
                                r_state <= ST_LOCKED;
                            end else begin
                                r_good <= r_good + 8'd1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_hlen_bad) begin
                            r_err_hlen <= 1'b1;
                            r_state    <= ST_SEARCH;
                        end
                        if (w_vlen_bad) begin
                            r_err_vlen <= 1'b1;
                            r_state    <= ST_SEARCH;
                        end
                        if (w_frame_ok)
                            r_frame_count <= r_frame_count + 16'd1;
                        // Blanking disagreement is reported but never costs lock.
                        if (r_blank_d != w_vis)
                            r_err_blank <= 1'b1;
                        if (w_vis && !w_hlen_bad && !w_vlen_bad)
                            r_pix_valid <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                    end
                endcase
            end
        end
    end

    assign DrawX       = r_hx;
    assign DrawY       = r_vy;
    assign pix_valid   = r_pix_valid;
    assign locked      = (r_state == ST_LOCKED);
    assign frame_count = r_frame_count;
    assign err_hlen    = r_err_hlen;
    assign err_vlen    = r_err_vlen;
    assign err_blank   = r_err_blank;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_monitor.sv
// ============================================================================
// Module  : tb_vga_timing_monitor
// Brief   : Self-checking bench for vga_timing_monitor on a reduced geometry.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_timing_monitor;

    localparam int HA  = 8;
    localparam int HT  = 16;
    localparam int HSS = 10;
    localparam int HSW = 2;
    localparam int VA  = 6;
    localparam int VT  = 10;
    localparam int VSS = 7;
    localparam int LF  = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pixel_clk = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        blank = 1'b0;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pix_valid;
    logic        locked;
    logic [15:0] frame_count;
    logic        err_hlen;
    logic        err_vlen;
    logic        err_blank;

    always #5 Clk = ~Clk;

    vga_timing_monitor #(
        .H_ACTIVE     (HA),
        .H_TOTAL      (HT),
        .H_SYNC_START (HSS),
        .V_ACTIVE     (VA),
        .V_TOTAL      (VT),
        .V_SYNC_START (VSS),
        .LOCK_FRAMES  (LF)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pixel_clk   (pixel_clk),
        .hs          (hs),
        .vs          (vs),
        .blank       (blank),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pix_valid   (pix_valid),
        .locked      (locked),
        .frame_count (frame_count),
        .err_hlen    (err_hlen),
        .err_vlen    (err_vlen),
        .err_blank   (err_blank)
    );

    typedef struct {
        int         due;
        logic [9:0] x;
        logic [9:0] y;
        logic       pv;
        bit         cxy;
        bit         cpv;
    } sb_t;

    typedef struct {
        int          vlines;
        int          short_y;
        int          gx;
        int          gy;
        bit          cxy;
        int          pvm;
        logic        lk;
        logic        eh;
        logic        ev;
        logic        eb;
        logic [15:0] fc;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[17];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   pv_cnt = 0;
    int   vs_falls = 0;
    int   vs_cyc = 0;
    bit   lock_watch = 1'b0;
    bit   prev_locked = 1'b0;
    bit   gen_vs_prev = 1'b1;
    bit   sb_xy = 1'b0;
    int   sb_pv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        sb_t e;
        @(negedge Clk);
        cyc++;
        if (pix_valid === 1'b1) pv_cnt++;
        if (lock_watch && locked === 1'b1 && !prev_locked) begin
            chk("lock_vs_falls", 64'(vs_falls), 64'd3);
            chk("lock_latency", 64'(cyc - vs_cyc), 64'd2);
            lock_watch = 1'b0;
        end
        prev_locked = (locked === 1'b1);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due == cyc) begin
                if (e.cxy) begin
                    chk("drawx", 64'(DrawX), 64'(e.x));
                    chk("drawy", 64'(DrawY), 64'(e.y));
                end
                if (e.cpv) chk("pix_valid", 64'(pix_valid), 64'(e.pv));
            end
        end
    endtask

    // One generator pixel: pixel_clk high for one Clk, low for the next.
    task automatic pixel(input int x, input int y, input bit gl, input bit do_rst);
        sb_t e;
        tick();
        pixel_clk = 1'b1;
        hs    = !(x >= HSS && x < HSS + HSW);
        vs    = (y != VSS);
        blank = (x < HA && y < VA) && !gl;
        if (gen_vs_prev && !vs) begin
            vs_falls++;
            vs_cyc = cyc;
        end
        gen_vs_prev = vs;
        if (sb_xy || sb_pv != 0) begin
            e.due = cyc + 2;
            e.x   = 10'(x);
            e.y   = 10'(y);
            e.pv  = (sb_pv == 1) && (x < HA) && (y < VA);
            e.cxy = sb_xy;
            e.cpv = (sb_pv != 0);
            sb.push_back(e);
        end
        if (do_rst) begin
            #2;
            Reset = 1'b1;
            sb.delete();
            #1;
            chk("async_reset", 64'({DrawX, DrawY, pix_valid, locked, frame_count,
                                    err_hlen, err_vlen, err_blank}), 64'd0);
        end
        tick();
        pixel_clk = 1'b0;
    endtask

    task automatic frame(input int vlines, input int short_y, input int gx, input int gy,
                         input int rx, input int ry);
        for (int y = 0; y < vlines; y++) begin
            for (int x = 0; x < ((y == short_y) ? HT - 1 : HT); x++) begin
                pixel(x, y, (x == gx && y == gy), (x == rx && y == ry));
            end
        end
    endtask

    initial begin
        //        vlines  sy  gx  gy  cxy pvm  lk    eh    ev    eb    fc
        tbl[0]  = '{VT,   -1, -1, -1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{VT,   -1, -1, -1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{VT,   -1, -1, -1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{VT,   -1, -1, -1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[4]  = '{VT,   -1, -1, -1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[5]  = '{VT,   -1, -1, -1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};
        tbl[6]  = '{VT,   -1,  3,  2, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4};
        tbl[7]  = '{VT,    2, -1, -1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd4};
        tbl[8]  = '{VT,   -1, -1, -1, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b1, 16'd4};
        tbl[9]  = '{VT,   -1, -1, -1, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b1, 16'd4};
        tbl[10] = '{VT,   -1, -1, -1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd5};
        tbl[11] = '{VT-1, -1, -1, -1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd6};
        tbl[12] = '{VT,   -1, -1, -1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd6};
        tbl[13] = '{VT,   -1, -1, -1, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b1, 16'd6};
        tbl[14] = '{VT,   -1, -1, -1, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b1, 16'd6};
        tbl[15] = '{VT,   -1, -1, -1, 1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 16'd6};
        tbl[16] = '{VT,   -1, -1, -1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd7};

        // Reset held while a nominal frame runs.
        frame(VT, -1, -1, -1, -1, -1);
        chk("reset_state", 64'({DrawX, DrawY, pix_valid, locked, frame_count,
                                err_hlen, err_vlen, err_blank}), 64'd0);
        Reset      = 1'b0;
        vs_falls   = 0;
        lock_watch = 1'b1;

        for (int i = 0; i < 17; i++) begin
            sb_xy  = tbl[i].cxy;
            sb_pv  = tbl[i].pvm;
            pv_cnt = 0;
            frame(tbl[i].vlines, tbl[i].short_y, tbl[i].gx, tbl[i].gy, -1, -1);
            chk($sformatf("v%0d_locked", i), 64'(locked), 64'(tbl[i].lk));
            chk($sformatf("v%0d_err_hlen", i), 64'(err_hlen), 64'(tbl[i].eh));
            chk($sformatf("v%0d_err_vlen", i), 64'(err_vlen), 64'(tbl[i].ev));
            chk($sformatf("v%0d_err_blank", i), 64'(err_blank), 64'(tbl[i].eb));
            chk($sformatf("v%0d_frame_count", i), 64'(frame_count), 64'(tbl[i].fc));
            if (tbl[i].pvm == 1)
                chk($sformatf("v%0d_pv_pulses", i), 64'(pv_cnt), 64'(HA * VA));
        end

        // pixel_clk stalled while locked: everything holds at the last pixel.
        repeat (1000) tick();
        chk("stall_drawx", 64'(DrawX), 64'(HT - 1));
        chk("stall_drawy", 64'(DrawY), 64'(VT - 1));
        chk("stall_status", 64'({pix_valid, locked, frame_count, err_hlen, err_vlen, err_blank}),
            64'({1'b0, 1'b1, 16'd7, 1'b1, 1'b1, 1'b1}));

        // Asynchronous reset mid-line, then a clean reacquisition.
        sb_xy = 1'b0;
        sb_pv = 0;
        frame(VT, -1, -1, -1, 5, 3);
        Reset      = 1'b0;
        vs_falls   = 0;
        lock_watch = 1'b1;
        frame(VT, -1, -1, -1, -1, -1);
        sb_xy = 1'b1;
        sb_pv = 2;
        frame(VT, -1, -1, -1, -1, -1);
        frame(VT, -1, -1, -1, -1, -1);
        chk("relock_seen", 64'(lock_watch), 64'd0);
        chk("relock_status", 64'({locked, frame_count, err_hlen, err_vlen, err_blank}),
            64'({1'b1, 16'd0, 1'b0, 1'b0, 1'b0}));
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Receive-side companion to the VGA timing generator. It watches the generator's `hs`, `vs`, `blank` and `pixel_clk` outputs and rebuilds the pixel coordinates from the sync pulses alone. It declares lock once frame geometry is stable, and flags line-length, frame-length and blanking errors. It sits beside the VGA controller at top level and feeds debug LEDs/HEX and any downstream pixel-capture logic that must not depend on the generator's internal `DrawX`/`DrawY`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_TOTAL`, 800: pixels per line, including blanking
- `H_SYNC_START`, 656: x coordinate of the pixel where `hs` first reads low
- `V_ACTIVE`, 480: visible lines per frame
- `V_TOTAL`, 525: lines per frame
- `V_SYNC_START`, 490: y coordinate of the line where `vs` first reads low
- `LOCK_FRAMES`, 2: consecutive good frames required for lock
- `Clk`  in  1  system clock, 50 MHz
- `Reset`  in  1  asynchronous, active-high reset
- `pixel_clk`  in  1  generator pixel clock (Clk/2), sampled as data
- `hs`  in  1  horizontal sync, active low
- `vs`  in  1  vertical sync, active low
- `blank`  in  1  1 = visible region, 0 = blanking
- `DrawX`  out  10  reconstructed x coordinate
- `DrawY`  out  10  reconstructed y coordinate
- `pix_valid`  out  1  one-Clk strobe: locked and the current pixel is visible
- `locked`  out  1  geometry verified
- `frame_count`  out  16  frames seen while locked; wraps
- `err_hlen`  out  1  sticky: a bad line length was seen
- `err_vlen`  out  1  sticky: a bad frame length was seen
- `err_blank`  out  1  sticky: `blank` disagreed with the reconstructed position

## Operation
- Register `pixel_clk` once.
- `pstb = pixel_clk & ~pixel_clk_q`, i.e. one Clk per pixel. All other logic advances only on `pstb`.
- On each `pstb`, sample `hs`/`vs`/`blank` and keep the previous samples.
- An edge is detected as prev = 1, current = 0.
- x counter `hx`:
  - An hs fall loads `H_SYNC_START`.
  - Otherwise, increment; `H_TOTAL-1` wraps to 0.
- y counter `vy`:
  - A vs fall loads `V_SYNC_START`. This has priority over the increment when both apply on the same `pstb`.
  - Otherwise, increment when `hx` wraps; `V_TOTAL-1` wraps to 0.
- Line-length counter:
  - Counts `pstb` between successive hs falls.
  - At each hs fall, compare the count with `H_TOTAL`, then restart the count at 1.
- Line counter:
  - Counts hs falls between successive vs falls.
  - At each vs fall, compare the count with `V_TOTAL`, then restart the count at 0.
- FSM states: SEARCH, ACQUIRE, LOCKED.
- SEARCH:
  - Go to ACQUIRE on the first vs fall.
  - Clear the good-frame counter and the measurement counters.
  - Ignore mismatches.
- ACQUIRE:
  - At each vs fall with no line-length mismatch since the previous vs fall and a line count equal to `V_TOTAL`, increment the good-frame counter. At `LOCK_FRAMES`, go to LOCKED.
  - Any mismatch clears the good-frame counter and the FSM stays in ACQUIRE.
  - No error flags are set.
- LOCKED:
  - A line-length mismatch sets `err_hlen`.
  - A frame-length mismatch sets `err_vlen`.
  - Either mismatch goes to SEARCH.
  - A vs fall with a good frame increments `frame_count`.
- Blank check, LOCKED only:
  - The expected value is `(hx < H_ACTIVE) && (vy < V_ACTIVE)`.
  - Any sampled `blank` that differs from the expected value sets `err_blank`.
  - A blank error does not drop lock.
- `pix_valid` = LOCKED and the expected visible value is 1, pulsed on the output cycle of that pixel.
- Error flags clear only on `Reset`.
- All widths are fixed at 10 bits for coordinates.
- Comparisons against parameters are unsigned.

## Timing
- Reset values: `DrawX` = 0, `DrawY` = 0, `pix_valid` = 0, `locked` = 0, `frame_count` = 0, all `err_*` = 0, FSM = SEARCH.
- Reset takes effect immediately and asynchronously, including mid-frame. After release, the block re-searches from the next vs fall.
- Latency:
  - `pixel_clk` rise → `pstb` takes 1 Clk.
  - Sample plus counter update are registered on `pstb`.
  - `DrawX`, `DrawY`, `pix_valid`, `locked` and `err_*` change on the Clk edge ending the `pstb` cycle. That is 2 Clk after the `pixel_clk` rise, and all of them are aligned.
- `locked` falls in the same cycle the mismatching edge is registered.
- Fastest lock from reset: first vs fall plus `LOCK_FRAMES` full frames.
- If `pixel_clk` stops, all state holds; no timeout.

## Test plan
- Reset with a nominal 640x480 stimulus running → all outputs 0. After release, `locked` = 1 exactly at the 3rd vs fall. No `err_*` flags are set.
- Locked nominal run, 3 frames → `DrawX`/`DrawY` equal the generator's coordinates delayed by 2 Clk at every `pstb`. `pix_valid` pulses 307200 times per frame. `frame_count` = 3.
- Locked, inject one 799-pixel line → `err_hlen` = 1 and `locked` = 0 at that hs fall. Relock after 1 vs fall + 2 good frames. `err_hlen` stays 1.
- Locked, inject a 524-line frame → `err_vlen` = 1, `locked` = 0. `frame_count` does not increment for that frame.
- Locked, force `blank` = 0 for a single pixel at (100,100) → `err_blank` = 1 and `locked` stays 1. `frame_count` = 0xFFFF followed by one good frame wraps to 0.
- Assert `Reset` mid-line at (300,200) → all outputs 0 in the same cycle. Stopping `pixel_clk` for 1000 Clk while locked leaves all outputs unchanged.
